ctrl_pkt_decoder: RTL and testbench



---
 rtl/ctrl_pkt_decoder_pkg.sv | 32 +++
 rtl/ctrl_pkt_decoder_if.sv | 32 +++
 rtl/ctrl_pkt_decoder.sv | 133 +++++++++++++
 tb/tb_ctrl_pkt_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkt_decoder_pkg.sv
// Shared constants and types for the control-packet decoder.
package ctrl_pkt_pkg;

  // UDP destination port that marks a control packet (matched upstream by the filter)
  localparam logic [15:0] CONTROL_PORT = 16'hf2f1;

  // Byte offsets of the control header fields inside beat 1
  localparam int MOD_ID_OFF = 10;
  localparam int RES_ID_OFF = 11;
  localparam int IDX_OFF    = 12;
  localparam int CNT_OFF    = 14;

  // Decoder states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  // Module IDs of the table RAMs addressed by cfg_wr_mod_id
  localparam logic [7:0] MOD_PARSER      = 8'h00;
  localparam logic [7:0] MOD_KEY_EXTRACT = 8'h01;
  localparam logic [7:0] MOD_LOOKUP      = 8'h02;
  localparam logic [7:0] MOD_ACTION      = 8'h03;

  // Header fields are big-endian on the wire: first byte is the high byte
  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ctrl_pkt_decoder_if.sv
// Control stream in / table-write command out bundle for the decoder.
interface ctrl_pkt_decoder_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int ADDR_W = 16
);
  // control stream from the packet filter (no tready: every beat is taken)
  logic [DATA_W-1:0]   ctrl_s_axis_tdata;
  logic [DATA_W/8-1:0] ctrl_s_axis_tkeep;
  logic [USER_W-1:0]   ctrl_s_axis_tuser;
  logic                ctrl_s_axis_tvalid;
  logic                ctrl_s_axis_tlast;

  // table-write command
  logic                cfg_wr_valid;
  logic [7:0]          cfg_wr_mod_id;
  logic [7:0]          cfg_wr_res_id;
  logic [ADDR_W-1:0]   cfg_wr_addr;
  logic [DATA_W-1:0]   cfg_wr_data;

  modport master (
    output ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser,
           ctrl_s_axis_tvalid, ctrl_s_axis_tlast,
    input  cfg_wr_valid, cfg_wr_mod_id, cfg_wr_res_id, cfg_wr_addr, cfg_wr_data
  );

  modport slave (
    input  ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser,
           ctrl_s_axis_tvalid, ctrl_s_axis_tlast,
    output cfg_wr_valid, cfg_wr_mod_id, cfg_wr_res_id, cfg_wr_addr, cfg_wr_data
  );
endinterface

// File: rtl/ctrl_pkt_decoder.sv
// Control-packet decoder: turns each payload beat of a control packet into
// one table-write command and keeps saturating good/bad packet counters.
module ctrl_pkt_decoder
  import ctrl_pkt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ADDR_WIDTH           = 16,
  parameter int MAX_ENTRIES          = 64,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  ctrl_pkt_decoder_if.slave    bus,
  output logic [CNT_WIDTH-1:0] stat_pkt_ok,
  output logic [CNT_WIDTH-1:0] stat_pkt_err
);

  // Only the 256-bit datapath is supported; the index field is 16 bits on the wire
  if (C_S_AXIS_DATA_WIDTH != 256 || C_S_AXIS_TUSER_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_params
    $error("ctrl_pkt_decoder: unsupported parameter set");
  end

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]           n, k, k_done, hdr_n, hdr_idx;
  logic                  bad;
  logic                  hdr_ld, wr_fire, mark_bad, ok_inc, err_inc;

  assign hdr_n   = be16(bus.ctrl_s_axis_tdata[CNT_OFF*8 +: 8],
                        bus.ctrl_s_axis_tdata[(CNT_OFF+1)*8 +: 8]);
  assign hdr_idx = be16(bus.ctrl_s_axis_tdata[IDX_OFF*8 +: 8],
                        bus.ctrl_s_axis_tdata[(IDX_OFF+1)*8 +: 8]);
  // entry count including a write issued on this beat
  assign k_done  = k + {15'd0, wr_fire};

  // Next-state and per-beat actions; idle cycles (tvalid=0) change nothing
  always_comb begin
    state_nxt = state;
    hdr_ld    = 1'b0;
    wr_fire   = 1'b0;
    mark_bad  = 1'b0;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;
    if (bus.ctrl_s_axis_tvalid) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.ctrl_s_axis_tlast) err_inc   = 1'b1;
          else                       state_nxt = ST_HDR;
        end
        ST_HDR: begin
          hdr_ld = 1'b1;
          if (bus.ctrl_s_axis_tlast) begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (hdr_n == 16'd0 || hdr_n > 16'(MAX_ENTRIES)) begin
            state_nxt = ST_DROP;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (k < n && (&bus.ctrl_s_axis_tkeep)) wr_fire  = 1'b1;
          else                                   mark_bad = 1'b1;
          if (bus.ctrl_s_axis_tlast) begin
            if (k_done == n && !bad && !mark_bad) ok_inc  = 1'b1;
            else                                  err_inc = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (bus.ctrl_s_axis_tlast) begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, header latches and entry counter
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      base              <= '0;
      n                 <= '0;
      k                 <= '0;
      bad               <= 1'b0;
      bus.cfg_wr_mod_id <= '0;
      bus.cfg_wr_res_id <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_ld) begin
        bus.cfg_wr_mod_id <= bus.ctrl_s_axis_tdata[MOD_ID_OFF*8 +: 8];
        bus.cfg_wr_res_id <= bus.ctrl_s_axis_tdata[RES_ID_OFF*8 +: 8];
        base              <= hdr_idx[ADDR_WIDTH-1:0];
        n                 <= hdr_n;
        k                 <= '0;
        bad               <= 1'b0;
      end
      if (wr_fire)  k   <= k_done;
      if (mark_bad) bad <= 1'b1;
    end
  end

  // Registered write command, one cycle after the payload beat
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bus.cfg_wr_valid <= 1'b0;
      bus.cfg_wr_addr  <= '0;
      bus.cfg_wr_data  <= '0;
    end else begin
      bus.cfg_wr_valid <= wr_fire;
      if (wr_fire) begin
        bus.cfg_wr_addr <= base + k[ADDR_WIDTH-1:0];
        bus.cfg_wr_data <= bus.ctrl_s_axis_tdata;
      end
    end
  end

  // Saturating good/bad packet counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pkt_ok  <= '0;
      stat_pkt_err <= '0;
    end else begin
      if (ok_inc  && !(&stat_pkt_ok))  stat_pkt_ok  <= stat_pkt_ok + 1'b1;
      if (err_inc && !(&stat_pkt_err)) stat_pkt_err <= stat_pkt_err + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_decoder.sv
// Bench for ctrl_pkt_decoder: directed and random packets against a
// packet-level reference model; counters use an 8-bit width so saturation is reachable.
module tb_ctrl_pkt_decoder;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    int           cyc;
  } beat_t;

  typedef struct {
    int           cyc;
    logic [7:0]   mod_id;
    logic [7:0]   res_id;
    logic [15:0]  addr;
    logic [255:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] stat_pkt_ok, stat_pkt_err;
  int            cyc = 0;
  int            n_cmp = 0, n_err = 0;
  int            m_ok = 0, m_err = 0;
  beat_t         pkt[$];
  wr_t           exp_q[$], got_q[$];

  ctrl_pkt_decoder_if bus ();

  ctrl_pkt_decoder #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .bus          (bus),
    .stat_pkt_ok  (stat_pkt_ok),
    .stat_pkt_err (stat_pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture every write strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (bus.cfg_wr_valid === 1'b1) begin
      wr_t w;
      w.cyc = cyc; w.mod_id = bus.cfg_wr_mod_id; w.res_id = bus.cfg_wr_res_id;
      w.addr = bus.cfg_wr_addr; w.data = bus.cfg_wr_data;
      got_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // header beat 0 + header beat 1 + npay payload beats, random contents
  task automatic build(input logic [7:0] m, input logic [7:0] r, input logic [15:0] idx,
                       input logic [15:0] n, input int npay);
    beat_t b;
    pkt.delete();
    for (int i = 0; i < npay + 2; i++) begin
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = 32'hFFFF_FFFF; b.last = 1'b0; b.cyc = 0;
      if (i == 1) begin
        b.data[87:80]   = m;
        b.data[95:88]   = r;
        b.data[103:96]  = idx[15:8];
        b.data[111:104] = idx[7:0];
        b.data[119:112] = n[15:8];
        b.data[127:120] = n[7:0];
      end
      pkt.push_back(b);
    end
    pkt[pkt.size()-1].last = 1'b1;
  endtask

  // drive the packet, 0..maxgap idle cycles before each beat; called at posedge+1
  task automatic send(input int maxgap);
    for (int i = 0; i < pkt.size(); i++) begin
      int gap;
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      repeat (gap) begin
        bus.ctrl_s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.ctrl_s_axis_tdata  = pkt[i].data;
      bus.ctrl_s_axis_tkeep  = pkt[i].keep;
      bus.ctrl_s_axis_tuser  = {4{$urandom}};
      bus.ctrl_s_axis_tlast  = pkt[i].last;
      bus.ctrl_s_axis_tvalid = 1'b1;
      pkt[i].cyc = cyc;
      @(posedge clk); #1;
    end
    bus.ctrl_s_axis_tvalid = 1'b0;
    bus.ctrl_s_axis_tlast  = 1'b0;
  endtask

  // packet-level reference: expected writes and counter outcome of pkt
  task automatic model_pkt();
    int k = 0;
    bit bad = 0;
    logic [15:0] n, base;
    if (pkt.size() < 3) bad = 1;
    else begin
      base = {pkt[1].data[103:96], pkt[1].data[111:104]};
      n    = {pkt[1].data[119:112], pkt[1].data[127:120]};
      if (n == 0 || n > 64) bad = 1;
      else begin
        for (int i = 2; i < pkt.size(); i++) begin
          if (k < n && pkt[i].keep == 32'hFFFF_FFFF) begin
            wr_t w;
            w.cyc = pkt[i].cyc + 1; w.mod_id = pkt[1].data[87:80]; w.res_id = pkt[1].data[95:88];
            w.addr = base + 16'(k); w.data = pkt[i].data;
            exp_q.push_back(w);
            k++;
          end else bad = 1;
        end
        if (k != n) bad = 1;
      end
    end
    if (bad) begin if (m_err < CMAX) m_err++; end
    else     begin if (m_ok  < CMAX) m_ok++;  end
  endtask

  task automatic check_pkt(input string tag);
    int nc;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".nwr"}, got_q.size(), exp_q.size());
    nc = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nc; i++) begin
      chk($sformatf("%s.w%0d.cyc", tag, i),  got_q[i].cyc,    exp_q[i].cyc);
      chk($sformatf("%s.w%0d.addr", tag, i), got_q[i].addr,   exp_q[i].addr);
      chk($sformatf("%s.w%0d.data", tag, i), got_q[i].data,   exp_q[i].data);
      chk($sformatf("%s.w%0d.mod", tag, i),  got_q[i].mod_id, exp_q[i].mod_id);
      chk($sformatf("%s.w%0d.res", tag, i),  got_q[i].res_id, exp_q[i].res_id);
    end
    chk({tag, ".ok"},  stat_pkt_ok,  m_ok);
    chk({tag, ".err"}, stat_pkt_err, m_err);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic run(input string tag, input int maxgap);
    send(maxgap);
    model_pkt();
    check_pkt(tag);
  endtask

  initial begin
    bus.ctrl_s_axis_tdata  = '0;
    bus.ctrl_s_axis_tkeep  = '0;
    bus.ctrl_s_axis_tuser  = '0;
    bus.ctrl_s_axis_tvalid = 1'b0;
    bus.ctrl_s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", bus.cfg_wr_valid,  0);
    chk("rst.addr",  bus.cfg_wr_addr,   0);
    chk("rst.data",  bus.cfg_wr_data,   0);
    chk("rst.mod",   bus.cfg_wr_mod_id, 0);
    chk("rst.res",   bus.cfg_wr_res_id, 0);
    chk("rst.ok",    stat_pkt_ok,       0);
    chk("rst.err",   stat_pkt_err,      0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;

    // good packet, back-to-back, directed payload patterns
    build(8'h02, 8'h01, 16'h0010, 16'd3, 3);
    pkt[2].data = {64{4'hA}}; pkt[3].data = {64{4'hB}}; pkt[4].data = {64{4'hC}};
    run("good", 0);
    // same packet with random tvalid gaps
    run("good_gap", 3);
    // short: N=4, packet ends after 2 payload beats
    build(8'h01, 8'h03, 16'h0100, 16'd4, 2);
    run("short_n4", 1);
    // long: N=1 with 3 payload beats
    build(8'h03, 8'h00, 16'h0200, 16'd1, 3);
    run("long_n1", 0);
    // invalid counts
    build(8'h00, 8'h02, 16'h0300, 16'd0, 1);
    run("n0", 0);
    build(8'h00, 8'h02, 16'h0300, 16'd65, 2);
    run("n65", 1);
    // header ends the packet
    build(8'h02, 8'h02, 16'h0400, 16'd2, 0);
    run("hdr_last", 0);
    // single-beat packet
    build(8'h02, 8'h02, 16'h0400, 16'd2, 0);
    pkt.delete(1);
    pkt[0].last = 1'b1;
    run("one_beat", 0);
    // index wrap, then the same with a partial-keep 2nd entry
    build(8'h01, 8'h01, 16'hFFFF, 16'd2, 2);
    run("wrap", 0);
    build(8'h01, 8'h01, 16'hFFFF, 16'd2, 2);
    pkt[3].keep = 32'h0000_FFFF;
    run("wrap_keep", 0);

    // random packets
    for (int t = 0; t < 30; t++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 64 + $urandom_range(0, 2) : $urandom_range(0, 6);
      build(8'($urandom), 8'($urandom), 16'($urandom), 16'(n),
            (n > 8) ? $urandom_range(0, 3) : n + $urandom_range(0, 3) - 1 + (n == 0 ? 1 : 0));
      if (pkt.size() > 2 && $urandom_range(0, 5) == 0)
        pkt[$urandom_range(2, pkt.size()-1)].keep = $urandom & 32'h7FFF_FFFF;
      run($sformatf("rnd%0d", t), $urandom_range(0, 2));
    end

    // reset in the middle of a payload
    build(8'h02, 8'h01, 16'h0020, 16'd4, 4);
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_s_axis_tdata  = pkt[i].data;
      bus.ctrl_s_axis_tkeep  = pkt[i].keep;
      bus.ctrl_s_axis_tlast  = pkt[i].last;
      bus.ctrl_s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    bus.ctrl_s_axis_tvalid = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst.valid", bus.cfg_wr_valid,  0);
    chk("mid_rst.addr",  bus.cfg_wr_addr,   0);
    chk("mid_rst.data",  bus.cfg_wr_data,   0);
    chk("mid_rst.mod",   bus.cfg_wr_mod_id, 0);
    chk("mid_rst.res",   bus.cfg_wr_res_id, 0);
    chk("mid_rst.ok",    stat_pkt_ok,       0);
    chk("mid_rst.err",   stat_pkt_err,      0);
    m_ok = 0; m_err = 0;
    @(negedge clk);
    got_q.delete(); exp_q.delete();
    aresetn = 1'b1;
    @(posedge clk); #1;
    build(8'h03, 8'h02, 16'h0040, 16'd3, 3);
    run("post_rst", 1);

    // drive the good counter to saturation, then one more good packet
    while (m_ok < CMAX) begin
      build(8'($urandom), 8'($urandom), 16'($urandom), 16'd1, 1);
      send(0);
      model_pkt();
    end
    check_pkt("sat_fill");
    build(8'h02, 8'h01, 16'h0010, 16'd1, 1);
    run("sat", 0);
    chk("sat.ok_max", stat_pkt_ok, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
